// File: rtl/mem_pkg.sv
// Shared definitions for the unified-memory arbiter and its lane-alignment helper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package mem_pkg;

    // RV32I load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    // RV32I store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_t;

    // Encodings that are never legal, plus the unsigned forms that only exist for loads.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
               (is_store && ((f3 == F3_LBU) || (f3 == F3_LHU)));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte/half/word lane steering for stores and lane extraction plus sign/zero extension for loads.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs every cycle.
module lsu_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_steered,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [31:0] shifted;

    // Bring the addressed lane down to bit 0 before extension.
    assign shifted = rdata >> {addr_lo, 3'b000};

    // Halfwords must sit on even addresses, words on multiples of four.
    assign misalign = ((funct3[1:0] == F3_SH[1:0]) && addr_lo[0]) ||
                      ((funct3[1:0] == F3_SW[1:0]) && (addr_lo != 2'b00));

    // Store steering: replicate narrow data across lanes and enable only the addressed bytes.
    always_comb begin
        be            = 4'b1111;
        wdata_steered = wdata;
        case (funct3)
            F3_SB: begin
                be            = 4'b0001 << addr_lo;
                wdata_steered = {4{wdata[7:0]}};
            end
            F3_SH: begin
                be            = 4'b0011 << addr_lo;
                wdata_steered = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction: signed forms replicate the lane's top bit, unsigned forms pad with zeros.
    always_comb begin
        rdata_ext = rdata;
        case (funct3)
            F3_LB:   rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  rdata_ext = {24'b0, shifted[7:0]};
            F3_LHU:  rdata_ext = {16'b0, shifted[15:0]};
            F3_LW:   rdata_ext = rdata;
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and load/store, DM first.
// Latency: legal access acks MEM_LAT+2 cycles after the request is first seen; illegal acks after 1.
// Backpressure: requesters hold their request until the one-cycle ack; nothing is queued.
module mem_access_arbiter
    import mem_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [2:0]        dm_funct3,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_ack,
    output logic [31:0]       dm_rdata,
    output logic              dm_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    localparam logic [3:0] WAIT_INIT = 4'(MEM_LAT - 1);

    state_t            state, state_d;
    logic [3:0]        cnt, cnt_d;
    owner_t            own, own_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        alo_q, alo_d;
    logic              wr_q, wr_d;

    logic              if_ack_d, if_err_d, dm_ack_d, dm_err_d;
    logic [31:0]       if_rdata_d, dm_rdata_d;
    logic              mem_en_d, mem_we_d;
    logic [3:0]        mem_be_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [31:0]       mem_wdata_d;
    logic              busy_d;

    logic [2:0]        lsu_f3;
    logic [1:0]        lsu_alo;
    logic [3:0]        lsu_be;
    logic [31:0]       lsu_wdata;
    logic [31:0]       lsu_rdata;
    logic              lsu_mis;
    logic              dm_illegal;

    // In IDLE the aligner looks at the live request (for steering and checks);
    // afterwards it looks at the captured request so late input changes are ignored.
    assign lsu_f3  = (state == IDLE) ? dm_funct3    : f3_q;
    assign lsu_alo = (state == IDLE) ? dm_addr[1:0] : alo_q;

    lsu_align u_align (
        .funct3        (lsu_f3),
        .addr_lo       (lsu_alo),
        .wdata         (dm_wdata),
        .rdata         (mem_rdata),
        .be            (lsu_be),
        .wdata_steered (lsu_wdata),
        .rdata_ext     (lsu_rdata),
        .misalign      (lsu_mis)
    );

    assign dm_illegal = (dm_read & dm_write) | f3_illegal(dm_funct3, dm_write) | lsu_mis;

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        own_d       = own;
        f3_d        = f3_q;
        alo_d       = alo_q;
        wr_d        = wr_q;
        if_ack_d    = 1'b0;
        if_err_d    = 1'b0;
        if_rdata_d  = 32'b0;
        dm_ack_d    = 1'b0;
        dm_err_d    = 1'b0;
        dm_rdata_d  = 32'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_be_d    = 4'b0;
        mem_addr_d  = '0;
        mem_wdata_d = 32'b0;
        case (state)
            IDLE: begin
                if (dm_read || dm_write) begin
                    own_d = OWN_DM;
                    f3_d  = dm_funct3;
                    alo_d = dm_addr[1:0];
                    wr_d  = dm_write;
                    if (dm_illegal) begin
                        state_d  = ACK;
                        dm_ack_d = 1'b1;
                        dm_err_d = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        mem_en_d    = 1'b1;
                        mem_we_d    = dm_write;
                        mem_be_d    = dm_write ? lsu_be : 4'b1111;
                        mem_addr_d  = {dm_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_d = dm_write ? lsu_wdata : 32'b0;
                    end
                end else if (if_req) begin
                    own_d = OWN_IF;
                    wr_d  = 1'b0;
                    if (if_addr[1:0] != 2'b00) begin
                        state_d  = ACK;
                        if_ack_d = 1'b1;
                        if_err_d = 1'b1;
                    end else begin
                        state_d    = ISSUE;
                        mem_en_d   = 1'b1;
                        mem_be_d   = 4'b1111;
                        mem_addr_d = if_addr;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = WAIT_INIT;
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_d = ACK;
                    if (own == OWN_DM) begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = wr_q ? 32'b0 : lsu_rdata;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // FSM state and captured request context.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            own   <= OWN_IF;
            f3_q  <= 3'd0;
            alo_q <= 2'd0;
            wr_q  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            own   <= own_d;
            f3_q  <= f3_d;
            alo_q <= alo_d;
            wr_q  <= wr_d;
        end
    end

    // Output registers; reset clears them so an abandoned access leaves no trace.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_ack    <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= 32'b0;
            dm_ack    <= 1'b0;
            dm_err    <= 1'b0;
            dm_rdata  <= 32'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'b0;
            busy      <= 1'b0;
        end else begin
            if_ack    <= if_ack_d;
            if_err    <= if_err_d;
            if_rdata  <= if_rdata_d;
            dm_ack    <= dm_ack_d;
            dm_err    <= dm_err_d;
            dm_rdata  <= dm_rdata_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_be    <= mem_be_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            busy      <= busy_d;
        end
    end

endmodule
